frame_accumulator: RTL

FRAME_ACCUMULATOR -- requirements
Module: frame_accumulator

---
 rtl/frame_accumulator.sv | 113 +++++++++++
 1 files changed

// File: rtl/frame_accumulator.sv
// Frame accumulator: two-stage pipeline summing samples and squared samples
// over frames of 2^FRAME_LEN_LOG2 accepted samples.
module frame_accumulator #(
  parameter int unsigned FRAME_LEN_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  sample,
  input  logic        sample_valid,
  output logic [23:0] sum,
  output logic [23:0] sum_sq,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                    state_q, state_d;
  logic                      s1_valid_q, s1_valid_d;
  logic [7:0]                s1_smp_q, s1_smp_d;
  logic [15:0]               s1_sq_q, s1_sq_d;
  logic [23:0]               acc_sum_q, acc_sum_d;
  logic [23:0]               acc_sq_q, acc_sq_d;
  logic [23:0]               sum_q, sum_d;
  logic [23:0]               sum_sq_q, sum_sq_d;
  logic [FRAME_LEN_LOG2-1:0] cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      accept;
  logic [23:0]               add_sum, add_sq;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)  state_d = ACCUM;
      ACCUM:   if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept  = (state_q == ACCUM) && en && sample_valid;
  assign add_sum = acc_sum_q + 24'(s1_smp_q);
  assign add_sq  = acc_sq_q + 24'(s1_sq_q);

  always_comb begin
    s1_valid_d = accept;
    s1_smp_d   = s1_smp_q;
    s1_sq_d    = s1_sq_q;
    acc_sum_d  = acc_sum_q;
    acc_sq_d   = acc_sq_q;
    sum_d      = sum_q;
    sum_sq_d   = sum_sq_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;

    if (accept) begin
      s1_smp_d = sample;
      s1_sq_d  = 16'(sample) * 16'(sample);
    end

    // en low discards the partial frame, including a sample still in stage 1
    if (!en) begin
      cnt_d     = '0;
      acc_sum_d = '0;
      acc_sq_d  = '0;
    end else if (s1_valid_q) begin
      if (cnt_q == '1) begin
        sum_d     = add_sum;
        sum_sq_d  = add_sq;
        done_d    = 1'b1;
        acc_sum_d = '0;
        acc_sq_d  = '0;
        cnt_d     = '0;
      end else begin
        acc_sum_d = add_sum;
        acc_sq_d  = add_sq;
        cnt_d     = cnt_q + FRAME_LEN_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s1_valid_q <= 1'b0;
      s1_smp_q   <= '0;
      s1_sq_q    <= '0;
      acc_sum_q  <= '0;
      acc_sq_q   <= '0;
      sum_q      <= '0;
      sum_sq_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_smp_q   <= s1_smp_d;
      s1_sq_q    <= s1_sq_d;
      acc_sum_q  <= acc_sum_d;
      acc_sq_q   <= acc_sq_d;
      sum_q      <= sum_d;
      sum_sq_q   <= sum_sq_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign sum        = sum_q;
  assign sum_sq     = sum_sq_q;
  assign frame_done = done_q;
  assign busy       = s1_valid_q | (cnt_q != '0);

endmodule
